// File: rtl/multdiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: default sizes,
// FSM state codes and the exception-cause encoding seen by the status register.
package multdiv_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_TAG_W = 5;

    localparam logic [DEF_WIDTH-1:0] INT_MIN = {1'b1, {(DEF_WIDTH-1){1'b0}}};

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_MUL  = 2'd1;
    localparam state_t ST_DIV  = 2'd2;
    localparam state_t ST_DONE = 2'd3;

    typedef enum logic [1:0] {
        EXC_NONE     = 2'd0,
        EXC_MUL_OVF  = 2'd1,
        EXC_DIV_ZERO = 2'd2,
        EXC_DIV_OVF  = 2'd3
    } exc_cause_t;

endpackage

// File: rtl/div_restoring_step.sv
// One restoring-division step on unsigned magnitudes: trial-subtract the divisor
// from the shifted partial remainder and keep the difference when it does not borrow.
module div_restoring_step
    import multdiv_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH:0]   partial_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             q_bit_o
);

    logic [WIDTH:0] diff;

    // The partial remainder is always below 2*divisor, so the top bit of the
    // difference is exactly the borrow.
    assign diff    = partial_i - {1'b0, divisor_i};
    assign q_bit_o = ~diff[WIDTH];
    assign rem_o   = q_bit_o ? diff[WIDTH-1:0] : partial_i[WIDTH-1:0];

endmodule

// File: rtl/multdiv_unit.sv
// Iterative signed multiply/divide unit: one shift-add or restoring step per cycle
// on operand magnitudes, sign applied at the end, fixed WIDTH+1 cycle latency.
module multdiv_unit
    import multdiv_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int TAG_W = DEF_TAG_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic [TAG_W-1:0] tag_in,
    output logic             busy,
    output logic             data_resultRDY,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic [TAG_W-1:0] tag_out
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   mag_b_q, mag_b_d;
    logic               neg_q, neg_d;
    logic               is_div_q, is_div_d;
    logic               zero_div_q, zero_div_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic               busy_q, busy_d;
    logic               rdy_q, rdy_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic               exc_q, exc_d;
    logic [TAG_W-1:0]   tag_out_q, tag_out_d;

    logic               start;
    logic [WIDTH-1:0]   mag_a_in, mag_b_in;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH-1:0]   div_rem;
    logic               div_q_bit;
    logic [2*WIDTH-1:0] prod_signed;
    logic [WIDTH-1:0]   quo_mag, quo_signed;
    logic [WIDTH-1:0]   fin_result;
    exc_cause_t         cause;

    assign start    = ctrl_MULT | ctrl_DIV;
    assign mag_a_in = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    assign mag_b_in = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;

    // Multiply keeps {carry+high, multiplier} in acc and shifts right each step;
    // divide keeps {remainder, dividend/quotient} and shifts left.
    assign mul_sum = acc_q[2*WIDTH:WIDTH] + (acc_q[0] ? {1'b0, mag_b_q} : '0);

    div_restoring_step #(.WIDTH(WIDTH)) u_div_step (
        .partial_i (  {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]}),
        .divisor_i (mag_b_q),
        .rem_o     (div_rem),
        .q_bit_o   (div_q_bit)
    );

    assign prod_signed = neg_q ? -acc_q[2*WIDTH-1:0] : acc_q[2*WIDTH-1:0];
    assign quo_mag     = acc_q[WIDTH-1:0];
    assign quo_signed  = neg_q ? -quo_mag : quo_mag;

    always_comb begin
        cause      = EXC_NONE;
        fin_result = '0;
        if (is_div_q) begin
            if (zero_div_q) begin
                cause = EXC_DIV_ZERO;
            end else if (!neg_q && quo_mag[WIDTH-1]) begin
                cause      = EXC_DIV_OVF;
                fin_result = quo_mag;
            end else begin
                fin_result = quo_signed;
            end
        end else begin
            fin_result = prod_signed[WIDTH-1:0];
            if (prod_signed[2*WIDTH-1:WIDTH] != {WIDTH{prod_signed[WIDTH-1]}}) begin
                cause = EXC_MUL_OVF;
            end
        end
    end

    always_comb begin
        // NOTE: every _d starts from its _q (rdy from 0) so no branch can leave a
        // signal unassigned and infer a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        mag_b_d    = mag_b_q;
        neg_d      = neg_q;
        is_div_d   = is_div_q;
        zero_div_d = zero_div_q;
        tag_d      = tag_q;
        busy_d     = busy_q;
        rdy_d      = 1'b0;
        res_d      = res_q;
        exc_d      = exc_q;
        tag_out_d  = tag_out_q;

        if (start) begin
            // A start in any state restarts; multiply wins over divide.
            state_d    = ctrl_MULT ? ST_MUL : ST_DIV;
            is_div_d   = ~ctrl_MULT;
            cnt_d      = '0;
            acc_d      = {{(WIDTH+1){1'b0}}, mag_a_in};
            mag_b_d    = mag_b_in;
            neg_d      = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            zero_div_d = (data_operandB == '0);
            tag_d      = tag_in;
            busy_d     = 1'b1;
        end else begin
            case (state_q)
                ST_MUL, ST_DIV: begin
                    if (state_q == ST_MUL) begin
                        acc_d = {1'b0, mul_sum, acc_q[WIDTH-1:1]};
                    end else begin
                        acc_d = {1'b0, div_rem, acc_q[WIDTH-2:0], div_q_bit};
                    end
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_STEP) begin
                        state_d = ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_d   = ST_IDLE;
                    busy_d    = 1'b0;
                    rdy_d     = 1'b1;
                    res_d     = fin_result;
                    exc_d     = (cause != EXC_NONE);
                    tag_out_d = tag_q;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            mag_b_q    <= '0;
            neg_q      <= 1'b0;
            is_div_q   <= 1'b0;
            zero_div_q <= 1'b0;
            tag_q      <= '0;
            busy_q     <= 1'b0;
            rdy_q      <= 1'b0;
            res_q      <= '0;
            exc_q      <= 1'b0;
            tag_out_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            mag_b_q    <= mag_b_d;
            neg_q      <= neg_d;
            is_div_q   <= is_div_d;
            zero_div_q <= zero_div_d;
            tag_q      <= tag_d;
            busy_q     <= busy_d;
            rdy_q      <= rdy_d;
            res_q      <= res_d;
            exc_q      <= exc_d;
            tag_out_q  <= tag_out_d;
        end
    end

    assign busy           = busy_q;
    assign data_resultRDY = rdy_q;
    assign data_result    = res_q;
    assign data_exception = exc_q;
    assign tag_out        = tag_out_q;

endmodule

// File: tb/tb_multdiv_unit.sv
// Self-checking bench for multdiv_unit: directed corner cases plus randomized
// operations against a plain-arithmetic reference model.
module tb_multdiv_unit;
    import multdiv_pkg::*;

    localparam int LATENCY = 33;
    localparam int LIMIT   = 100;

    logic        clock;
    logic        reset;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [4:0]  tag_in;
    logic        busy;
    logic        data_resultRDY;
    logic [31:0] data_result;
    logic        data_exception;
    logic [4:0]  tag_out;

    int n_cmp = 0;
    int n_err = 0;
    int rdy_count = 0;

    multdiv_unit dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .tag_in         (tag_in),
        .busy           (busy),
        .data_resultRDY (data_resultRDY),
        .data_result    (data_result),
        .data_exception (data_exception),
        .tag_out        (tag_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (data_resultRDY) rdy_count++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: signed 64-bit product or C-style truncating quotient.
    function automatic void model(input logic is_mul, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic e);
        longint p;
        int     ia, ib, q;
        ia = a;
        ib = b;
        if (is_mul) begin
            p = longint'(ia) * longint'(ib);
            r = p[31:0];
            e = (p[63:32] != {32{p[31]}});
        end else if (b == 32'd0) begin
            r = 32'd0;
            e = 1'b1;
        end else if (a == INT_MIN && b == 32'hFFFF_FFFF) begin
            r = INT_MIN;
            e = 1'b1;
        end else begin
            q = ia / ib;
            r = q;
            e = 1'b0;
        end
    endfunction

    // Called at a negedge; returns at the negedge after the sampling edge.
    task automatic start_op(input logic m, input logic d, input logic [31:0] a,
                            input logic [31:0] b, input logic [4:0] t);
        ctrl_MULT     = m;
        ctrl_DIV      = d;
        data_operandA = a;
        data_operandB = b;
        tag_in        = t;
        @(negedge clock);
        ctrl_MULT = 1'b0;
        ctrl_DIV  = 1'b0;
        check("busy after start", busy, 1);
    endtask

    task automatic finish_checked(input string name, input logic m, input logic [31:0] a,
                                  input logic [31:0] b, input logic [4:0] t, input int cnt0);
        int          lat;
        logic [31:0] exp_r;
        logic        exp_e;
        lat = 0;
        while (!data_resultRDY && lat < LIMIT) begin
            @(negedge clock);
            lat++;
        end
        model(m, a, b, exp_r, exp_e);
        check({name, " latency"}, lat, LATENCY);
        check({name, " result"}, data_result, exp_r);
        check({name, " exception"}, data_exception, exp_e);
        check({name, " tag"}, tag_out, t);
        @(negedge clock);
        #1;
        check({name, " rdy width"}, data_resultRDY, 0);
        check({name, " busy after"}, busy, 0);
        check({name, " rdy count"}, rdy_count - cnt0, 1);
    endtask

    task automatic run_checked(input string name, input logic m, input logic d,
                               input logic [31:0] a, input logic [31:0] b, input logic [4:0] t);
        int cnt0;
        cnt0 = rdy_count;
        start_op(m, d, a, b, t);
        finish_checked(name, m, a, b, t, cnt0);
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return INT_MIN;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 20));
            4:       return -32'($urandom_range(0, 20));
            default: return $urandom();
        endcase
    endfunction

    initial begin
        int cnt0;
        reset         = 1'b0;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = '0;
        data_operandB = '0;
        tag_in        = '0;
        repeat (3) @(negedge clock);
        check("reset busy", busy, 0);
        check("reset rdy", data_resultRDY, 0);
        check("reset result", data_result, 0);
        check("reset exception", data_exception, 0);
        check("reset tag", tag_out, 0);
        reset = 1'b1;
        @(negedge clock);

        run_checked("mul 7*-3", 1, 0, 32'd7, -32'd3, 5'd5);
        run_checked("mul ovf", 1, 0, 32'h0001_0000, 32'h0001_0000, 5'd1);
        run_checked("mul max", 1, 0, 32'h7FFF_FFFF, 32'd1, 5'd2);
        run_checked("div -7/2", 0, 1, -32'd7, 32'd2, 5'd3);
        run_checked("div by zero", 0, 1, 32'd100, 32'd0, 5'd4);
        run_checked("div intmin", 0, 1, INT_MIN, 32'hFFFF_FFFF, 5'd6);
        run_checked("both high", 1, 1, 32'd12, -32'd5, 5'd7);

        // Restart: a multiply issued 10 cycles into a divide replaces it.
        cnt0 = rdy_count;
        start_op(0, 1, 32'd100, 32'd7, 5'd3);
        repeat (9) @(negedge clock);
        start_op(1, 0, 32'd6, 32'd7, 5'd9);
        finish_checked("restart", 1, 32'd6, 32'd7, 5'd9, cnt0);

        // Asynchronous reset in the middle of a multiply.
        cnt0 = rdy_count;
        start_op(1, 0, 32'd1234, 32'd5678, 5'd11);
        repeat (14) @(negedge clock);
        #2 reset = 1'b0;
        #1;
        check("abort busy", busy, 0);
        check("abort rdy", data_resultRDY, 0);
        check("abort result", data_result, 0);
        check("abort exception", data_exception, 0);
        check("abort tag", tag_out, 0);
        @(negedge clock);
        reset = 1'b1;
        repeat (40) @(negedge clock);
        #1;
        check("abort no rdy", rdy_count - cnt0, 0);
        check("abort idle", busy, 0);
        @(negedge clock);
        run_checked("after abort", 0, 1, 32'd1000, -32'd7, 5'd13);

        for (int i = 0; i < 1000; i++) begin
            int          sel;
            logic        m, d;
            logic [31:0] a, b;
            sel = $urandom_range(0, 4);
            m   = (sel == 0 || sel == 1 || sel == 4);
            d   = (sel == 2 || sel == 3 || sel == 4);
            a   = rand_operand();
            b   = rand_operand();
            run_checked(m ? "rand mul" : "rand div", m, d, a, b, 5'($urandom()));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/multdiv_unit.md
Name: multdiv_unit

Overview:
- Iterative signed 32-bit multiply/divide unit beside the ALU in the execute stage; handles mul and div, which the single-cycle ALU does not.
- Processor pulses a start, stalls on busy, and consumes one registered result plus destination tag on the second register write port (enable/data pair).
- Fixed latency for every operation, including exceptions, so stall logic is trivial.

Parameters:
- WIDTH, 32, operand/result width in bits.
- TAG_W, 5, width of destination-register tag carried through.

Ports:
- clock  in  1  single clock, rising-edge.
- reset  in  1  asynchronous, active-low (asserted at 0).
- ctrl_MULT  in  1  one-cycle start pulse: signed multiply.
- ctrl_DIV  in  1  one-cycle start pulse: signed divide.
- data_operandA  in  WIDTH  multiplicand / dividend.
- data_operandB  in  WIDTH  multiplier / divisor.
- tag_in  in  TAG_W  destination register of the operation.
- busy  out  1  operation in flight.
- data_resultRDY  out  1  one-cycle result-valid pulse.
- data_result  out  WIDTH  low product word or quotient.
- data_exception  out  1  overflow / divide-by-zero, valid with RDY.
- tag_out  out  TAG_W  tag_in captured at start, valid with RDY.

Behaviour:
- Reset (async, reset=0): state IDLE; busy=0, data_resultRDY=0, data_result=0, data_exception=0, tag_out=0, counter=0.
- Reset mid-operation aborts immediately; no RDY is produced.
- FSM states: IDLE, MUL, DIV, DONE.
  - IDLE: ctrl_MULT -> MUL; else ctrl_DIV -> DIV. Operands and tag_in latch, counter=0.
  - MUL: one radix-2 shift-add step per cycle on magnitudes, sign fixed at end. After WIDTH steps -> DONE.
  - DIV: one restoring step per cycle on magnitudes. After WIDTH steps -> DONE.
  - DONE: registered outputs update, data_resultRDY=1 for exactly that cycle, -> IDLE.
- Latency: start sampled at edge N; data_resultRDY high during cycle after edge N+WIDTH+1 (33 cycles for WIDTH=32).
- busy is high from edge N until the edge leaving DONE.
- data_result, data_exception and tag_out hold their values until the next DONE.
- ctrl_MULT and ctrl_DIV both high: MULT wins, DIV ignored.
- Start while busy, including DONE: restart with the new operands and tag. In-flight result is discarded and no RDY is emitted for it.
- Multiply:
  - data_result = low WIDTH bits of the signed 2*WIDTH product.
  - data_exception=1 iff the upper WIDTH bits are not the sign extension of bit WIDTH-1.
- Divide:
  - Quotient truncates toward zero; remainder is discarded.
  - Divisor 0: data_result=0, data_exception=1, same latency.
  - Dividend 0x80000000 with divisor 0xFFFFFFFF: data_result=0x80000000, data_exception=1.
- Counter width: $clog2(WIDTH)+1; it does not wrap within an operation.
- Combinational outputs: none. All outputs are registered.

Decomposition:
- Shared package multdiv_pkg holds:
  - state enum (IDLE, MUL, DIV, DONE),
  - WIDTH default,
  - INT_MIN constant,
  - the exception-cause encoding used by the processor status register.
- One natural combinational sub-module, div_restoring_step: partial remainder and divisor in, next remainder and quotient bit out. It is instantiated once and used every DIV cycle.
- The multiply step stays inline.

Test Plan:
- Reset held 0 for 3 cycles, then ctrl_MULT with A=7, B=-3, tag 5 -> RDY exactly 33 cycles later, result 0xFFFFFFEB, exception 0, tag_out 5, busy low the next cycle.
- ctrl_MULT A=0x00010000, B=0x00010000 -> result 0x00000000, exception 1. A=0x7FFFFFFF, B=1 -> result 0x7FFFFFFF, exception 0.
- ctrl_DIV A=-7, B=2 -> result 0xFFFFFFFD (-3), exception 0. A=100, B=0 -> result 0, exception 1, latency 33. A=0x80000000, B=-1 -> result 0x80000000, exception 1.
- ctrl_DIV started, ctrl_MULT pulsed 10 cycles later with A=6, B=7, tag 9 -> exactly one RDY, 33 cycles after the second start, result 42, tag_out 9. Also drive ctrl_MULT and ctrl_DIV together -> multiply result is produced.
- reset pulsed 0 at cycle 15 of a multiply -> all outputs 0 asynchronously, no RDY afterwards. The next start completes normally.
- Randomized 1000 signed operand pairs against a reference model. Check result, exception, tag, and the single-cycle RDY width.
